// File: rtl/mem_bus_pkg.sv
// Shared request/response field definitions for the BRAM responder bus.
package mem_bus_pkg;

    localparam int MEM_TAG_W  = 8;
    localparam int MEM_ADDR_W = 26;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_BE_W   = MEM_DATA_W / 8;

    localparam logic [MEM_TAG_W-1:0] c_mem_tag_none = '0;

    typedef struct packed {
        logic                  request;
        logic [MEM_TAG_W-1:0]  tag;
        logic [MEM_ADDR_W-1:0] address;
        logic                  read_writen;
        logic [MEM_DATA_W-1:0] wdata;
        logic [MEM_BE_W-1:0]   byte_en;
    } t_mem_req;

    typedef struct packed {
        logic [MEM_TAG_W-1:0]  rack_tag;
        logic [MEM_TAG_W-1:0]  dack_tag;
        logic [MEM_DATA_W-1:0] data;
    } t_mem_resp;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } t_ack_state;

endpackage

// File: rtl/mem_bram_responder_if.sv
// Request/response bundle between an initiator and the BRAM responder.
interface mem_bram_responder_if;
    import mem_bus_pkg::*;

    logic                  mem_req_request;
    logic [MEM_TAG_W-1:0]  mem_req_tag;
    logic [MEM_ADDR_W-1:0] mem_req_address;
    logic                  mem_req_read_writen;
    logic [MEM_DATA_W-1:0] mem_req_wdata;
    logic [MEM_BE_W-1:0]   mem_req_byte_en;
    logic [MEM_TAG_W-1:0]  mem_resp_rack_tag;
    logic [MEM_TAG_W-1:0]  mem_resp_dack_tag;
    logic [MEM_DATA_W-1:0] mem_resp_data;

    modport master (
        output mem_req_request, mem_req_tag, mem_req_address,
               mem_req_read_writen, mem_req_wdata, mem_req_byte_en,
        input  mem_resp_rack_tag, mem_resp_dack_tag, mem_resp_data
    );

    modport slave (
        input  mem_req_request, mem_req_tag, mem_req_address,
               mem_req_read_writen, mem_req_wdata, mem_req_byte_en,
        output mem_resp_rack_tag, mem_resp_dack_tag, mem_resp_data
    );

endinterface

// File: rtl/mem_bram_be.sv
// Single-port byte-enabled RAM with registered read; a write and read of the
// same access return the freshly written word.
module mem_bram_be #(
    parameter int ADDR_BITS = 12
) (
    input  logic                 clock,
    input  logic                 en,
    input  logic                 we,
    input  logic [3:0]           be,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [31:0] mem [DEPTH];
    logic [31:0] merged;

    // Word as it will look after this access's enabled byte lanes are applied.
    always_comb begin
        merged = mem[addr];
        for (int i = 0; i < 4; i++) begin
            if (we && be[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    // Storage update and registered read port; contents are never reset.
    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                mem[addr] <= merged;
            end
            rdata <= merged;
        end
    end

endmodule

// File: rtl/mem_bram_responder.sv
// Memory-bus responder: wait-state acknowledge FSM in front of a byte-enabled
// BRAM, returning read data two cycles after acceptance.
module mem_bram_responder
    import mem_bus_pkg::*;
#(
    parameter int RAM_ADDR_BITS = 12,
    parameter int WAIT_STATES   = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    mem_bram_responder_if.slave  bus
);

    localparam logic [3:0] C_WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    t_mem_req   req;
    t_mem_resp  resp;
    t_ack_state state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       accept;
    logic       rd_accept;
    logic       ram_we;
    logic [RAM_ADDR_BITS-1:0] word_idx;
    logic [MEM_DATA_W-1:0]    ram_rdata;

    logic                 vld_p0;
    logic [MEM_TAG_W-1:0] tag_p0;
    logic [MEM_TAG_W-1:0] dack_tag_p1;
    logic [MEM_DATA_W-1:0] data_p1;

    logic unused_addr_bits;

    assign req.request     = bus.mem_req_request;
    assign req.tag         = bus.mem_req_tag;
    assign req.address     = bus.mem_req_address;
    assign req.read_writen = bus.mem_req_read_writen;
    assign req.wdata       = bus.mem_req_wdata;
    assign req.byte_en     = bus.mem_req_byte_en;

    // Byte offset and bits above the RAM depth are don't-care; upper addresses alias.
    assign word_idx         = req.address[RAM_ADDR_BITS+1:2];
    assign unused_addr_bits = ^req.address;

    assign rd_accept = accept && req.read_writen;
    assign ram_we    = accept && !req.read_writen;

    // Acknowledge FSM and wait counter state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: hold a request for WAIT_STATES cycles, abandon it if it drops.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req.request) begin
                    if (WAIT_STATES == 0) begin
                        accept = 1'b1;
                    end else begin
                        cnt_nxt   = C_WAIT_LOAD;
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!req.request) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == 4'd0) begin
                    accept    = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    mem_bram_be #(
        .ADDR_BITS (RAM_ADDR_BITS)
    ) u_ram (
        .clock (clock),
        .en    (accept),
        .we    (ram_we),
        .be    (req.byte_en),
        .addr  (word_idx),
        .wdata (req.wdata),
        .rdata (ram_rdata)
    );

    // Stage p0: tag of a read whose RAM word is being fetched.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_p0 <= 1'b0;
            tag_p0 <= c_mem_tag_none;
        end else begin
            vld_p0 <= rd_accept;
            tag_p0 <= rd_accept ? req.tag : c_mem_tag_none;
        end
    end

    // Stage p1: output register; data holds between completions.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dack_tag_p1 <= c_mem_tag_none;
            data_p1     <= '0;
        end else begin
            dack_tag_p1 <= vld_p0 ? tag_p0 : c_mem_tag_none;
            if (vld_p0) begin
                data_p1 <= ram_rdata;
            end
        end
    end

    assign resp.rack_tag = accept ? req.tag : c_mem_tag_none;
    assign resp.dack_tag = dack_tag_p1;
    assign resp.data     = data_p1;

    assign bus.mem_resp_rack_tag = resp.rack_tag;
    assign bus.mem_resp_dack_tag = resp.dack_tag;
    assign bus.mem_resp_data     = resp.data;

endmodule

// File: tb/tb_mem_bram_responder.sv
// Bench for mem_bram_responder: zero-wait-state instance driven from a vector
// table with a read scoreboard, plus a three-wait-state instance for timing cases.
module tb_mem_bram_responder;
    import mem_bus_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    mem_bram_responder_if bus0 ();
    mem_bram_responder_if bus3 ();

    mem_bram_responder #(.RAM_ADDR_BITS(12), .WAIT_STATES(0)) dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0.slave)
    );

    mem_bram_responder #(.RAM_ADDR_BITS(12), .WAIT_STATES(3)) dut3 (
        .clock (clock),
        .reset (reset),
        .bus   (bus3.slave)
    );

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  tag;
        logic [31:0] data;
        int unsigned due;
    } t_exp;

    typedef struct {
        logic        rd;
        logic [25:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [7:0]  tag;
        logic [31:0] exp_data;
    } t_vec;

    t_exp sb[$];
    t_vec vec[15];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set0(input logic req, input logic rd, input logic [25:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input logic [7:0] tag);
        bus0.mem_req_request     = req;
        bus0.mem_req_read_writen = rd;
        bus0.mem_req_address     = addr;
        bus0.mem_req_wdata       = wdata;
        bus0.mem_req_byte_en     = be;
        bus0.mem_req_tag         = tag;
    endtask

    task automatic set3(input logic req, input logic rd, input logic [25:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input logic [7:0] tag);
        bus3.mem_req_request     = req;
        bus3.mem_req_read_writen = rd;
        bus3.mem_req_address     = addr;
        bus3.mem_req_wdata       = wdata;
        bus3.mem_req_byte_en     = be;
        bus3.mem_req_tag         = tag;
    endtask

    // Read completions of the zero-wait instance against the scoreboard.
    always @(negedge clock) begin
        t_exp e;
        if (bus0.mem_resp_dack_tag != 8'h00) begin
            if (sb.size() == 0) begin
                chk("unexpected_dack", {24'h0, bus0.mem_resp_dack_tag}, 32'h0);
            end else begin
                e = sb.pop_front();
                chk("dack_tag", {24'h0, bus0.mem_resp_dack_tag}, {24'h0, e.tag});
                chk("dack_data", bus0.mem_resp_data, e.data);
                chk("dack_cycle", cyc, e.due);
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            chk("dack_missing", {24'h0, bus0.mem_resp_dack_tag}, {24'h0, e.tag});
        end
    end

    initial begin
        int got;

        vec[0]  = '{1'b0, 26'h000100, 32'hDEADBEEF, 4'hF, 8'h11, 32'h0};
        vec[1]  = '{1'b1, 26'h000100, 32'h0,       4'h0, 8'h12, 32'hDEADBEEF};
        vec[2]  = '{1'b0, 26'h000100, 32'h000000AA, 4'h1, 8'h13, 32'h0};
        vec[3]  = '{1'b1, 26'h000100, 32'h0,       4'h0, 8'h14, 32'hDEADBEAA};
        vec[4]  = '{1'b0, 26'h000200, 32'hCAFEF00D, 4'hF, 8'h15, 32'h0};
        vec[5]  = '{1'b0, 26'h004000, 32'h12345678, 4'hF, 8'h16, 32'h0};
        vec[6]  = '{1'b1, 26'h000000, 32'h0,       4'h0, 8'h17, 32'h12345678};
        vec[7]  = '{1'b0, 26'h000200, 32'hFFFFFFFF, 4'h0, 8'h18, 32'h0};
        vec[8]  = '{1'b1, 26'h000202, 32'h0,       4'h0, 8'h19, 32'hCAFEF00D};
        vec[9]  = '{1'b0, 26'h000200, 32'h11223344, 4'h6, 8'h1A, 32'h0};
        vec[10] = '{1'b1, 26'h000200, 32'h0,       4'h0, 8'h1B, 32'hCA22330D};
        vec[11] = '{1'b1, 26'h000100, 32'h0,       4'h0, 8'h31, 32'hDEADBEAA};
        vec[12] = '{1'b1, 26'h000200, 32'h0,       4'h0, 8'h32, 32'hCA22330D};
        vec[13] = '{1'b1, 26'h000003, 32'h0,       4'h0, 8'h33, 32'h12345678};
        vec[14] = '{1'b1, 26'h000100, 32'h0,       4'h0, 8'h34, 32'hDEADBEAA};

        set0(1'b0, 1'b1, '0, '0, '0, 8'h00);
        set3(1'b0, 1'b1, '0, '0, '0, 8'h00);

        // Outputs while reset is held.
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_rack0", {24'h0, bus0.mem_resp_rack_tag}, 32'h0);
        chk("rst_dack0", {24'h0, bus0.mem_resp_dack_tag}, 32'h0);
        chk("rst_data0", bus0.mem_resp_data, 32'h0);
        chk("rst_dack3", {24'h0, bus3.mem_resp_dack_tag}, 32'h0);

        // Release and stream the vector table, first request right at release.
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            set0(1'b1, vec[i].rd, vec[i].addr, vec[i].wdata, vec[i].be, vec[i].tag);
            @(negedge clock);
            chk($sformatf("rack_vec%0d", i), {24'h0, bus0.mem_resp_rack_tag}, {24'h0, vec[i].tag});
            if (vec[i].rd) sb.push_back('{vec[i].tag, vec[i].exp_data, cyc + 2});
            @(posedge clock);
            #1;
        end
        set0(1'b0, 1'b1, '0, '0, '0, 8'h00);
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clock);
        if (sb.size() > 0) chk("drain_stream", sb.size(), 0);

        // Idle cycles: no dack, data holds the last completion.
        repeat (2) @(negedge clock);
        chk("idle_dack", {24'h0, bus0.mem_resp_dack_tag}, 32'h0);
        chk("idle_data_hold", bus0.mem_resp_data, 32'hDEADBEAA);
        chk("idle_rack", {24'h0, bus0.mem_resp_rack_tag}, 32'h0);

        // Reset right after a read acceptance must discard that read.
        @(posedge clock);
        #1;
        set0(1'b1, 1'b1, 26'h000100, '0, '0, 8'h41);
        @(negedge clock);
        chk("rack_41", {24'h0, bus0.mem_resp_rack_tag}, 32'h41);
        @(posedge clock);
        #1;
        set0(1'b0, 1'b1, '0, '0, '0, 8'h00);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("midrst_dack", {24'h0, bus0.mem_resp_dack_tag}, 32'h0);
            chk("midrst_data", bus0.mem_resp_data, 32'h0);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("postrst_dack", {24'h0, bus0.mem_resp_dack_tag}, 32'h0);
        @(posedge clock);
        #1;
        set0(1'b1, 1'b1, 26'h000100, '0, '0, 8'h42);
        @(negedge clock);
        chk("rack_42", {24'h0, bus0.mem_resp_rack_tag}, 32'h42);
        sb.push_back('{8'h42, 32'hDEADBEAA, cyc + 2});
        @(posedge clock);
        #1;
        set0(1'b0, 1'b1, '0, '0, '0, 8'h00);
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clock);
        if (sb.size() > 0) chk("drain_after_reset", sb.size(), 0);

        // Three wait states: held write is acknowledged on the third cycle.
        @(posedge clock);
        #1;
        set3(1'b1, 1'b0, 26'h000000, 32'h0BADF00D, 4'hF, 8'h20);
        got = 99;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (bus3.mem_resp_rack_tag == 8'h20) begin
                got = k;
                break;
            end
        end
        chk("ws3_write_delay", got, 3);
        @(posedge clock);
        #1;
        set3(1'b1, 1'b1, 26'h000000, '0, '0, 8'h21);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk($sformatf("ws3_rack_c%0d", k), {24'h0, bus3.mem_resp_rack_tag},
                (k == 3) ? 32'h21 : 32'h0);
            if (k < 3) begin
                @(posedge clock);
                #1;
            end
        end
        @(posedge clock);
        #1;
        set3(1'b0, 1'b1, '0, '0, '0, 8'h00);
        @(negedge clock);
        chk("ws3_dack_early", {24'h0, bus3.mem_resp_dack_tag}, 32'h0);
        @(negedge clock);
        chk("ws3_dack_tag", {24'h0, bus3.mem_resp_dack_tag}, 32'h21);
        chk("ws3_dack_data", bus3.mem_resp_data, 32'h0BADF00D);

        // Request dropped during wait: no acknowledge, no write.
        @(posedge clock);
        #1;
        set3(1'b1, 1'b0, 26'h000000, 32'hFFFFFFFF, 4'hF, 8'h22);
        repeat (2) begin
            @(negedge clock);
            chk("ws3_abort_rack", {24'h0, bus3.mem_resp_rack_tag}, 32'h0);
        end
        @(posedge clock);
        #1;
        set3(1'b0, 1'b1, '0, '0, '0, 8'h00);
        @(negedge clock);
        chk("ws3_abort_rack_after", {24'h0, bus3.mem_resp_rack_tag}, 32'h0);
        @(posedge clock);
        #1;
        set3(1'b1, 1'b1, 26'h000000, '0, '0, 8'h23);
        got = 99;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (bus3.mem_resp_rack_tag == 8'h23) begin
                got = k;
                break;
            end
        end
        chk("ws3_reread_delay", got, 3);
        @(posedge clock);
        #1;
        set3(1'b0, 1'b1, '0, '0, '0, 8'h00);
        repeat (2) @(negedge clock);
        chk("ws3_reread_tag", {24'h0, bus3.mem_resp_dack_tag}, 32'h23);
        chk("ws3_reread_data", bus3.mem_resp_data, 32'h0BADF00D);

        repeat (2) @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bram_responder.md
MEM_BRAM_RESPONDER -- requirements
Module: mem_bram_responder

Interface
REQ-001 SHALL have parameter RAM_ADDR_BITS, default 12: log2 of RAM depth in 32-bit words.
REQ-002 SHALL have parameter WAIT_STATES, default 0, range 0..15: extra cycles a request is held before acknowledge.
REQ-003 SHALL have port clock, input, 1: single clock, all logic rising-edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port mem_req_request, input, 1: request valid, held by the initiator until acknowledged.
REQ-006 SHALL have port mem_req_tag, input, 8: request tag, nonzero.
REQ-007 SHALL have port mem_req_address, input, 26: byte address.
REQ-008 SHALL have port mem_req_read_writen, input, 1: 1 = read, 0 = write.
REQ-009 SHALL have port mem_req_wdata, input, 32: write data.
REQ-010 SHALL have port mem_req_byte_en, input, 4: write byte enables; bit n covers wdata[8n+7:8n].
REQ-011 SHALL have port mem_resp_rack_tag, output, 8: tag of the request accepted this cycle, else 0.
REQ-012 SHALL have port mem_resp_dack_tag, output, 8: tag of the read whose data is valid this cycle, else 0.
REQ-013 SHALL have port mem_resp_data, output, 32: read data, valid when dack_tag is nonzero.

Function
REQ-014 SHALL compute the word index as mem_req_address[RAM_ADDR_BITS+1:2]; address bits [1:0] and the upper bits SHALL be ignored, so upper addresses alias.
REQ-015 SHALL implement the acknowledge FSM with states IDLE and WAIT.
- IDLE: when request=1 and WAIT_STATES=0, accept the request this cycle. When request=1 and WAIT_STATES>0, load the counter with WAIT_STATES-1 and go to WAIT.
- WAIT: decrement the counter each cycle. When the counter is 0, accept the request and return to IDLE.
REQ-016 On acceptance, rack_tag SHALL equal mem_req_tag combinationally in the same cycle; otherwise rack_tag SHALL be 0.
REQ-017 An accepted write SHALL update only the enabled bytes at the rising edge that ends the acceptance cycle.
REQ-018 An accepted write with byte_en=0000 SHALL leave the RAM unchanged and SHALL still be acknowledged.
REQ-019 An accepted read SHALL produce dack_tag = tag and data = RAM word exactly 2 cycles after the acceptance cycle: RAM read stage, then output register.
REQ-020 dack_tag SHALL be 0 in every cycle that has no read completion, and mem_resp_data SHALL hold its last value in those cycles.
REQ-021 With WAIT_STATES=0, back-to-back requests SHALL be accepted every cycle, and read completions SHALL stream one per cycle in acceptance order.
REQ-022 A read accepted in the cycle immediately after a write to the same word SHALL return the newly written data (write-then-read coherency).
REQ-023 A read and a write in consecutive accepts to different words SHALL not disturb each other.
REQ-024 If request drops while in WAIT, which is a protocol violation, the FSM SHALL return to IDLE without acknowledging and without writing.
REQ-025 Tag value 0 on an accepted request SHALL be treated as a valid transfer, but its rack and dack are indistinguishable from idle; the bench SHALL not issue tag 0.

Reset
REQ-026 While reset is asserted: the FSM SHALL be in IDLE, the counter 0, rack_tag 0, dack_tag 0, mem_resp_data 0, and the read pipeline valid flags cleared.
REQ-027 Reset asserted mid-operation SHALL discard in-flight reads; their dack SHALL never appear.
REQ-028 RAM contents SHALL not be reset.
REQ-029 The first acceptance after reset release SHALL be possible in the first clock edge after release.

Structure
REQ-030 The request and response fields SHALL be defined as t_mem_req and t_mem_resp in the shared mem_bus_pkg, with constant c_mem_tag_none = 0.
REQ-031 The byte-enabled single-port RAM SHALL be a sub-module, mem_bram_be (depth 2^RAM_ADDR_BITS, 4 byte lanes, registered read, read-after-write returns new data).
REQ-032 The FSM, counter and tag pipeline SHALL reside in mem_bram_responder.

Verification
REQ-033 Write 0xDEADBEEF to address 0x000100 with byte_en 1111 and tag 0x11, then read it with tag 0x12 -> rack_tag 0x11 and then 0x12 in the acceptance cycles; 2 cycles after the read acceptance, dack_tag 0x12 and data 0xDEADBEEF.
REQ-034 Write 0x000000AA to 0x000100 with byte_en 0001, then read -> data 0xDEADBEAA.
REQ-035 With WAIT_STATES=3, a held read request with tag 0x21 -> rack_tag 0x21 exactly 3 cycles after request rises; dack 2 cycles after that.
REQ-036 Four back-to-back reads with tags 0x31..0x34 at WAIT_STATES=0 -> four consecutive dack cycles with tags 0x31..0x34 in order.
REQ-037 With RAM_ADDR_BITS=12, write 0x12345678 to 0x004000, then read 0x000000 -> data 0x12345678 (alias).
REQ-038 Accept a read with tag 0x41, assert reset on the next cycle -> dack_tag stays 0 and all outputs are 0 during reset; the RAM still holds its prior data after release.
